// File: rtl/dec24_pulse.sv
// rtl/dec24_pulse.sv - sequential 2-to-4 decoder driving a one-hot line for hold_len cycles
// Optional: define DEC24_REARM_EN to accept a new code in the last drive cycle.
module dec24_pulse #(
   parameter int HOLD_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              code_valid,
   input  logic [1:0]        code,
   input  logic [HOLD_W-1:0] hold_len,
   output logic              code_ready,
   output logic [3:0]        d_out,
   output logic              busy,
   output logic              done
);

   typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

   localparam logic [HOLD_W-1:0] ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

   state_t            r_state, w_state_nxt;
   logic [HOLD_W-1:0] r_cnt, w_cnt_nxt, w_len_m1;
   logic [3:0]        r_d_out, w_d_nxt;
   logic              r_done, w_done_nxt;
   logic              w_last, w_accept;

   // cnt holds the number of drive cycles remaining after the current one
   assign w_last   = (r_state == DRIVE) && (r_cnt == '0);
   assign w_len_m1 = (hold_len == '0) ? '0 : hold_len - ONE;
   assign w_accept = code_valid & code_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_d_out <= 4'b0000;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_d_out <= w_d_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_d_nxt     = r_d_out;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = DRIVE;
               w_cnt_nxt   = w_len_m1;
               w_d_nxt     = 4'b0001 << code;
            end
         end
         DRIVE: begin
            if (!en) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_d_nxt     = 4'b0000;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - ONE;
            end else begin
               w_done_nxt = 1'b1;
               if (w_accept) begin
                  w_cnt_nxt = w_len_m1;
                  w_d_nxt   = 4'b0001 << code;
               end else begin
                  w_state_nxt = IDLE;
                  w_d_nxt     = 4'b0000;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
`ifdef DEC24_REARM_EN
      code_ready = ((r_state == IDLE) | w_last) & en & ~rst;
`else
      code_ready = (r_state == IDLE) & en & ~rst & ~w_last;
`endif
      busy  = (r_state == DRIVE);
      d_out = r_d_out;
      done  = r_done;
   end

endmodule

// File: tb/tb_dec24_pulse.sv
// tb/tb_dec24_pulse.sv - self-checking bench for dec24_pulse against a cycle-count model
module tb_dec24_pulse;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       code_valid = 1'b0;
   logic [1:0] code = 2'b00;
   logic [3:0] hold_len = 4'd0;
   logic       code_ready;
   logic [3:0] d_out;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   // model: visible drive cycles left, selected line, pending done
   int         m_left = 0;
   int         m_line = 0;
   logic       m_done = 1'b0;

   dec24_pulse #(.HOLD_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .code_valid(code_valid), .code(code),
      .hold_len(hold_len), .code_ready(code_ready), .d_out(d_out),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ready();
`ifdef DEC24_REARM_EN
      return !rst && en && (m_left <= 1);
`else
      return !rst && en && (m_left == 0);
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      logic acc;
      if (rst) begin
         m_left = 0;
         m_done = 1'b0;
      end else begin
         acc    = code_valid && model_ready();
         m_done = 1'b0;
         if (m_left > 0 && !en) begin
            m_left = 0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
         end
         if (acc) begin
            m_line = code;
            m_left = (hold_len == 0) ? 1 : hold_len;
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] exp_d;
      exp_d = (m_left > 0) ? (4'b0001 << m_line) : 4'b0000;
      check("cyc_d_out", d_out, exp_d);
      check("cyc_busy", busy, m_left > 0);
      check("cyc_done", done, m_done);
      check("cyc_ready", code_ready, model_ready());
      check("cyc_onehot", $countones(d_out) <= 1, 1);
      if (done) done_cnt++;
   end

   task automatic send(input logic [1:0] c, input logic [3:0] l, output int waited);
      logic ok;
      ok = 1'b0;
      waited = 0;
      code = c;
      hold_len = l;
      code_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = code_ready;
         @(posedge clk);
         waited++;
      end
      #1 code_valid = 1'b0;
      check("accept_ok", ok, 1);
   endtask

   initial begin
      int w;
      int n;
      int d0;
      logic [3:0] exp_tab [4];
      exp_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_d_out", d_out, 4'b0000);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", code_ready, 0);
      rst = 1'b0;
      en = 1'b1;
      #1 check("post_rst_ready", code_ready, 1);

      // basic decode: line 2 for three cycles, then one done pulse
      @(posedge clk); #1;
      send(2'b10, 4'd3, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("basic_d_out", d_out, 4'b0100);
         check("basic_ready", code_ready, 0);
         check("basic_done_low", done, 0);
      end
      @(negedge clk);
      check("basic_end_d_out", d_out, 4'b0000);
      check("basic_done", done, 1);
      @(negedge clk);
      check("basic_done_once", done, 0);

      // hold_len 0 behaves as a single cycle for every code
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         send(c[1:0], 4'd0, w);
         @(negedge clk);
         check("sweep_d_out", d_out, exp_tab[c]);
         @(negedge clk);
         check("sweep_end", d_out, 4'b0000);
         check("sweep_done", done, 1);
      end

      // abort after four drive cycles
      @(posedge clk); #1;
      d0 = done_cnt;
      send(2'b11, 4'd10, w);
      repeat (3) @(posedge clk);
      #1 en = 1'b0;
      @(posedge clk); #1;
      check("abort_d_out", d_out, 4'b0000);
      check("abort_done", done, 0);
      check("abort_ready", code_ready, 0);
      repeat (2) @(posedge clk);
      #1 check("abort_ready_hold", code_ready, 0);
      check("abort_no_done", done_cnt - d0, 0);
      en = 1'b1;
      #1 check("abort_ready_back", code_ready, 1);

      // second code presented while busy
      @(posedge clk); #1;
      d0 = done_cnt;
      send(2'b00, 4'd5, w);
      send(2'b01, 4'd2, w);
`ifdef DEC24_REARM_EN
      check("busy_wait_edges", w, 5);
`else
      check("busy_wait_edges", w, 6);
`endif
      repeat (4) @(posedge clk);
      #1 check("busy_done_count", done_cnt - d0, 2);

      // maximum length
      send(2'b01, 4'hF, w);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (d_out != 4'b0000) n++;
      end
      check("max_len_cycles", n, 15);

      // async reset in mid drive
      @(posedge clk); #1;
      d0 = done_cnt;
      send(2'b10, 4'd5, w);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_d_out", d_out, 4'b0000);
      check("arst_busy", busy, 0);
      check("arst_ready", code_ready, 0);
      @(posedge clk); #1 rst = 1'b0;
      #1 check("arst_ready_back", code_ready, 1);
      repeat (3) @(posedge clk);
      #1 check("arst_no_done", done_cnt - d0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
